// File: rtl/rev_pkg.sv
`default_nettype none
// ============================================================================
// rev_pkg : shared types and helpers for the bit-reverse scheduler
// Rev 1.0
// ============================================================================
package rev_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam int BUSY_CNT_W = 16;

  // Round-robin successor: the requester after idx, wrapping to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_reverser.sv
`default_nettype none
// ============================================================================
// param_reverser : combinational bit reversal, out[i] = in[WIDTH-1-i]
// Rev 1.0
// ============================================================================
module param_reverser #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] out_word
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign out_word[i] = in_word[WIDTH-1-i];
  end

endmodule
`default_nettype wire

// File: rtl/rev_scheduler.sv
`default_nettype none
// ============================================================================
// rev_scheduler : round-robin shared bit-reverse service with one output register
// Rev 1.0
// ============================================================================
module rev_scheduler
  import rev_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic [BUSY_CNT_W-1:0]  busy_cnt
);

  out_state_t      state;
  out_state_t      state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand_idx;
  int              cand;
  logic            grant_found;
  logic            can_accept;
  logic            xfer;
  logic [WIDTH-1:0] grant_word;
  logic [WIDTH-1:0] rev_word;

  // First asserted valid at or after rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign can_accept = (state == EMPTY) || rsp_ready;
  assign xfer       = rst_n && can_accept && grant_found;
  assign grant_word = req_data[grant_idx*WIDTH +: WIDTH];
  assign rsp_valid  = (state == FULL);

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready[k] = xfer && (grant_idx == ID_W'(k));
    end
  end

  param_reverser #(
    .WIDTH(WIDTH)
  ) u_reverser (
    .in_word (grant_word),
    .out_word(rev_word)
  );

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = FULL;
    end else if ((state == FULL) && rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      rr_ptr   <= '0;
      busy_cnt <= '0;
    end else begin
      if (xfer) begin
        rsp_data <= rev_word;
        rsp_id   <= grant_idx;
        rr_ptr   <= ID_W'(rr_next(32'(grant_idx), N_REQ));
      end
      if ((state == FULL) && !rsp_ready && (busy_cnt != {BUSY_CNT_W{1'b1}})) begin
        busy_cnt <= busy_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rev_scheduler.md
Name: rev_scheduler

Overview:
- Shares one combinational bit-reverse datapath (`param_reverser`) among `n_req` requesters.
- Each requester has a valid/ready handshake. A round-robin arbiter selects one requester per cycle, and the reversed word is captured in a single registered output stage tagged with the requester ID.
- Sits between multiple producer blocks and one downstream consumer, providing a 1-cycle-latency, full-throughput reversal service.

Parameters:
- width, 8, data word width in bits (>=1)
- n_req, 4, number of requesters (>=2)
- id_w, $clog2(n_req), width of requester ID field (derived; not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  n_req  per-requester data valid
- req_data  in  n_req*width  packed request words; requester k occupies [k*width +: width]
- req_ready  out  n_req  per-requester accept; at most one bit set per cycle
- rsp_valid  out  1  output register holds a valid result
- rsp_data  out  width  bit-reversed word: rsp_data[i] = captured_word[width-1-i]
- rsp_id  out  id_w  index of the requester that produced rsp_data
- rsp_ready  in  1  downstream accepts the result
- busy_cnt  out  16  saturating count of cycles with rsp_valid=1 and rsp_ready=0 (backpressure stall monitor)

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy_cnt=0.
  - Round-robin pointer rr_ptr=0; output FSM in EMPTY.
  - req_ready=0 while rst_n is low.
- Output FSM states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready. This is combinational and permits back-to-back transfers.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, ascending with wrap from n_req-1 to 0.
  - The first asserted index is g. If no req_valid is asserted, there is no grant.
- req_ready[g] = can_accept & grant_exists. All other req_ready bits are 0.
  - req_ready never depends on another requester's req_ready.
- Transfer occurs when req_valid[g] & req_ready[g]. On that clock edge:
  - rsp_data <= reverse(req_data[g]).
  - rsp_id <= g.
  - State -> FULL.
  - rr_ptr <= (g==n_req-1) ? 0 : g+1.
- FULL & rsp_ready & no new transfer: state -> EMPTY. rsp_data/rsp_id hold their last values.
- FULL & rsp_ready & new transfer: state stays FULL, and the register loads the new word in the same cycle (throughput 1 word/clk).
- FULL & !rsp_ready: the register is held stable, all req_ready=0, and rr_ptr is frozen.
- Latency: the request handshake at edge N presents the result at the output after edge N (visible in cycle N+1).
- rr_ptr advances only on a completed transfer, never on idle cycles.
- Requesters must hold req_data stable while req_valid=1 and not yet accepted. A requester may drop req_valid without acceptance; the arbiter re-evaluates every cycle.
- busy_cnt:
  - Increments when state==FULL & !rsp_ready.
  - Saturates at 16'hFFFF.
  - Clears only on reset.
- Reset asserted mid-operation clears the pending result immediately. The result is lost and is not replayed.
- width=1: reversal is identity; all control behaviour is unchanged.

Decomposition:
- Shared package (rev_pkg):
  - output FSM state enum {EMPTY, FULL}
  - BUSY_CNT_W=16 constant
  - function computing the next round-robin index with wrap
- Sub-module: `param_reverser` (existing combinational reverser), instantiated once with width=width on the arbiter-selected word.
- Round-robin arbiter logic stays inline. It is small, and the team does not split it out.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[7:0]=8'b0000_0001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=8'b1000_0000, rsp_id=0; rr_ptr=1.
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0 with no bubbles.
- One result in FULL, then rsp_ready=0 for 5 cycles with req_valid=4'b1111:
  - all req_ready=0 and rsp_data stable for 5 cycles
  - busy_cnt=5
  - after rsp_ready rises, the next grant goes to the index following the last served.
- req_data[1]=8'hA5, req_data[2]=8'h0F with only requesters 1,2 valid, rr_ptr=3 -> wrap selects 1 first (rsp_data=8'hA5 reversed=8'hA5), then 2 (rsp_data=8'hF0).
- rst_n pulsed low mid-stream while FULL with rsp_data=8'h3C:
  - rsp_valid drops asynchronously; rsp_data=0, rsp_id=0, busy_cnt=0
  - after release, arbitration restarts at requester 0.
- Stall with rsp_ready=0 held for 70000 cycles -> busy_cnt saturates at 16'hFFFF and does not wrap.
